reg_file_rename: RTL and testbench
==================================

// Module: reg_file_rename
// PURPOSE
//  Architectural register file with per-register rename status (busy + ROB tag).
//  Sits beside decode/ROB: decode renames rd to a ROB slot at issue; ROB commit
//  writes the retired value here. Source reads return the value when ready,
//  otherwise the producing ROB tag.
//  Mispredict flush clears all busy bits.
// PARAMETERS
//  XLEN   32  data width
//  NREG   32  architectural registers (x0 hardwired zero)
//  ROB_W  4   ROB tag width (16 entries)
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  rdy        in   1      global enable; 0 = hold all state
//  flush      in   1      mispredict: clear every busy bit
//  rn_en      in   1      issue renames rn_rd this cycle
//  rn_rd      in   5      destination register being renamed
//  rn_tag     in   ROB_W  ROB slot allocated to rn_rd
//  cm_en      in   1      ROB commits a register write this cycle
//  cm_rd      in   5      committed destination
//  cm_tag     in   ROB_W  ROB slot being committed
//  cm_val     in   XLEN   committed value
//  rs1_addr   in   5      source 1 index
//  rs2_addr   in   5      source 2 index
//  rs1_ready  out  1      1 = rs1_val holds data; 0 = holds tag
//  rs2_ready  out  1      as rs1_ready
//  rs1_val    out  XLEN   data, or {zero-ext, tag} when not ready
//  rs2_val    out  XLEN   as rs1_val
//  instret    out  64     count of commits accepted (cm_en && rdy)
// BEHAVIOUR
//  - State: regs[NREG], busy[NREG], tag[NREG], instret. Reset: all zero.
//  - rst overrides flush/rn/cm; reset mid-operation discards every pending rename.
//  - rdy=0: no state update; read outputs stay combinationally valid.
//  - Reads are combinational, zero latency; priority per port:
//    1. addr==0 -> ready=1, val=0.
//    2. !busy[addr] -> ready=1, val=regs[addr].
//    3. cm_en && cm_rd==addr && cm_tag==tag[addr] -> ready=1, val=cm_val (bypass).
//    4. else ready=0, val={(XLEN-ROB_W)'b0, tag[addr]}.
//  - Reads see pre-rename state: a same-cycle rn_rd==rs does not affect the port
//    (same instruction reads sources before renaming rd).
//  - Commit (posedge, rdy, cm_en, cm_rd!=0): regs[cm_rd]<=cm_val always;
//    busy[cm_rd]<=0 only if tag[cm_rd]==cm_tag (no younger rename); instret+1.
//    cm_rd==0: no write, instret still increments.
//  - Rename (posedge, rdy, rn_en, rn_rd!=0, !flush): busy<=1, tag<=rn_tag.
//  - Rename and commit same rd same cycle: regs written, busy stays 1, tag=rn_tag.
//  - flush: all busy<=0; rename same cycle ignored; same-cycle commit still
//    writes regs and counts (older instruction).
//  - instret wraps at 2^64.
// TESTING
//  - Reset, read x5 -> ready=1, val=0; instret=0.
//  - Rename x5 tag 3; read x5 -> ready=0, val=3; commit x5 tag3 val 0xDEAD ->
//    next cycle ready=1, val=0xDEAD.
//  - Rename x5 tag3, then x5 tag7; commit tag3 val 1 -> regs[x5]=1, ready=0, val=7.
//  - Busy x6 tag2; same cycle cm x6 tag2 val 0x55 and read x6 -> ready=1, val=0x55.
//  - Rename x8 tag4 with flush=1 -> x8 ready=1; busy x9 then flush -> x9 ready=1,
//    holds last committed value.
//  - rn_rd=0 tag1 and cm_rd=0 val 0xFF -> x0 reads 0, ready=1; instret increments;
//    rdy=0 with cm_en -> no change.

Source files
------------

// File: rtl/reg_file_rename_if.sv
// Bundle between decode/ROB and the renaming register file: rename and
// commit requests, two source read ports and the retired-instruction count.
interface reg_file_rename_if #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4
) ();
    logic             rdy;
    logic             flush;
    logic             rn_en;
    logic [4:0]       rn_rd;
    logic [ROB_W-1:0] rn_tag;
    logic             cm_en;
    logic [4:0]       cm_rd;
    logic [ROB_W-1:0] cm_tag;
    logic [XLEN-1:0]  cm_val;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic             rs1_ready;
    logic             rs2_ready;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [63:0]      instret;

    modport master (
        output rdy, flush, rn_en, rn_rd, rn_tag,
        output cm_en, cm_rd, cm_tag, cm_val,
        output rs1_addr, rs2_addr,
        input  rs1_ready, rs2_ready, rs1_val, rs2_val, instret
    );

    modport slave (
        input  rdy, flush, rn_en, rn_rd, rn_tag,
        input  cm_en, cm_rd, cm_tag, cm_val,
        input  rs1_addr, rs2_addr,
        output rs1_ready, rs2_ready, rs1_val, rs2_val, instret
    );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Sources read combinationally: the value when ready, the producing ROB tag
// otherwise, with a bypass from the commit that retires the matching tag.
// Reads always see the state from before this cycle's rename.
module reg_file_rename #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    reg_file_rename_if.slave bus
);
    logic [XLEN-1:0]  regs_r [NREG];
    logic [ROB_W-1:0] tag_r  [NREG];
    logic [NREG-1:0]  busy_r;
    logic [63:0]      instret_r;

    logic [XLEN:0]    rs1_s;
    logic [XLEN:0]    rs2_s;
    logic             cm_wr_s;
    logic             rn_wr_s;

    // Resolve one source port: returns {ready, value-or-tag}.
    function automatic logic [XLEN:0] read_port(
        input logic [4:0]       addr,
        input logic             busy,
        input logic [ROB_W-1:0] tag,
        input logic [XLEN-1:0]  val,
        input logic             cm_en,
        input logic [4:0]       cm_rd,
        input logic [ROB_W-1:0] cm_tag,
        input logic [XLEN-1:0]  cm_val
    );
        logic [XLEN:0] res;
        if (addr == 5'd0) begin
            res = {1'b1, {XLEN{1'b0}}};
        end else if (!busy) begin
            res = {1'b1, val};
        end else if (cm_en && (cm_rd == addr) && (cm_tag == tag)) begin
            res = {1'b1, cm_val};
        end else begin
            res = {1'b0, {(XLEN-ROB_W){1'b0}}, tag};
        end
        return res;
    endfunction

    // Qualify commit and rename writes; x0 is never written or renamed,
    // and a flush kills a same-cycle rename.
    always_comb begin
        cm_wr_s = 1'b0;
        rn_wr_s = 1'b0;
        if (bus.rdy) begin
            cm_wr_s = bus.cm_en && (bus.cm_rd != 5'd0);
            rn_wr_s = bus.rn_en && (bus.rn_rd != 5'd0) && !bus.flush;
        end else begin
            cm_wr_s = 1'b0;
            rn_wr_s = 1'b0;
        end
    end

    // Source port 1 lookup against pre-rename state.
    always_comb begin
        rs1_s = read_port(bus.rs1_addr, busy_r[bus.rs1_addr], tag_r[bus.rs1_addr],
                          regs_r[bus.rs1_addr], bus.cm_en, bus.cm_rd, bus.cm_tag,
                          bus.cm_val);
    end

    // Source port 2 lookup against pre-rename state.
    always_comb begin
        rs2_s = read_port(bus.rs2_addr, busy_r[bus.rs2_addr], tag_r[bus.rs2_addr],
                          regs_r[bus.rs2_addr], bus.cm_en, bus.cm_rd, bus.cm_tag,
                          bus.cm_val);
    end

    assign bus.rs1_ready = rs1_s[XLEN];
    assign bus.rs1_val   = rs1_s[XLEN-1:0];
    assign bus.rs2_ready = rs2_s[XLEN];
    assign bus.rs2_val   = rs2_s[XLEN-1:0];
    assign bus.instret   = instret_r;

    // Retired values land in the architectural file even under flush,
    // since the committing instruction is older than the mispredict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (cm_wr_s) begin
            regs_r[bus.cm_rd] <= bus.cm_val;
        end else begin
            regs_r[bus.cm_rd] <= regs_r[bus.cm_rd];
        end
    end

    // Rename status: commit clears busy only when no younger rename replaced
    // the tag; flush clears everything; a rename (placed last) wins over a
    // same-cycle commit to the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {NREG{1'b0}};
            for (int i = 0; i < NREG; i++) begin
                tag_r[i] <= {ROB_W{1'b0}};
            end
        end else if (bus.rdy) begin
            if (cm_wr_s && (tag_r[bus.cm_rd] == bus.cm_tag)) begin
                busy_r[bus.cm_rd] <= 1'b0;
            end
            if (bus.flush) begin
                busy_r <= {NREG{1'b0}};
            end else if (rn_wr_s) begin
                busy_r[bus.rn_rd] <= 1'b1;
                tag_r[bus.rn_rd]  <= bus.rn_tag;
            end
        end else begin
            busy_r <= busy_r;
        end
    end

    // Every accepted commit counts, including writes to x0; wraps at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_r <= 64'd0;
        end else if (bus.rdy && bus.cm_en) begin
            instret_r <= instret_r + 64'd1;
        end else begin
            instret_r <= instret_r;
        end
    end
endmodule

// File: tb/tb_reg_file_rename.sv
// Directed test of reg_file_rename: reset state, rename/commit, tag
// replacement, commit bypass, flush interactions, x0 and rdy hold.
module tb_reg_file_rename;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    reg_file_rename_if #(.XLEN(32), .ROB_W(4)) bus ();

    reg_file_rename #(.XLEN(32), .NREG(32), .ROB_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rn_en = 1'b0;
        bus.cm_en = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] tg);
        bus.rn_en  = 1'b1;
        bus.rn_rd  = rd;
        bus.rn_tag = tg;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] tg, input logic [31:0] v);
        bus.cm_en  = 1'b1;
        bus.cm_rd  = rd;
        bus.cm_tag = tg;
        bus.cm_val = v;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.rn_rd = 5'd0;  bus.rn_tag = 4'd0;
        bus.cm_rd = 5'd0;  bus.cm_tag = 4'd0; bus.cm_val = 32'd0;
        bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
        idle();
        step();
        step();
        rst = 1'b0;

        // Reset state
        bus.rs1_addr = 5'd5;
        #1;
        check_eq("rst_rdy", {63'd0, bus.rs1_ready}, 64'd1);
        check_eq("rst_val", {32'd0, bus.rs1_val}, 64'd0);
        check_eq("rst_x0", {32'd0, bus.rs2_val}, 64'd0);
        check_eq("rst_instret", bus.instret, 64'd0);

        // Rename x5 tag 3: same-cycle read still sees pre-rename state
        rename(5'd5, 4'd3);
        #1;
        check_eq("pre_rn_rdy", {63'd0, bus.rs1_ready}, 64'd1);
        step();
        idle();
        #1;
        check_eq("rn_rdy", {63'd0, bus.rs1_ready}, 64'd0);
        check_eq("rn_tag", {32'd0, bus.rs1_val}, 64'd3);
        commit(5'd5, 4'd3, 32'hDEAD);
        #1;
        check_eq("cm_byp_rdy", {63'd0, bus.rs1_ready}, 64'd1);
        check_eq("cm_byp_val", {32'd0, bus.rs1_val}, 64'hDEAD);
        step();
        idle();
        #1;
        check_eq("cm_rdy", {63'd0, bus.rs1_ready}, 64'd1);
        check_eq("cm_val", {32'd0, bus.rs1_val}, 64'hDEAD);
        check_eq("instret1", bus.instret, 64'd1);

        // Younger rename: older commit writes regs but x5 stays busy on tag 7
        rename(5'd5, 4'd3); step();
        rename(5'd5, 4'd7); step();
        idle();
        commit(5'd5, 4'd3, 32'd1);
        #1;
        check_eq("old_cm_nobyp", {63'd0, bus.rs1_ready}, 64'd0);
        step();
        idle();
        #1;
        check_eq("young_rdy", {63'd0, bus.rs1_ready}, 64'd0);
        check_eq("young_tag", {32'd0, bus.rs1_val}, 64'd7);
        check_eq("instret2", bus.instret, 64'd2);
        bus.flush = 1'b1; step(); idle();
        #1;
        check_eq("old_cm_reg", {32'd0, bus.rs1_val}, 64'd1);

        // Commit bypass on port 2
        rename(5'd6, 4'd2); step(); idle();
        bus.rs2_addr = 5'd6;
        commit(5'd6, 4'd2, 32'h55);
        #1;
        check_eq("byp2_rdy", {63'd0, bus.rs2_ready}, 64'd1);
        check_eq("byp2_val", {32'd0, bus.rs2_val}, 64'h55);
        step(); idle();
        #1;
        check_eq("x6_val", {32'd0, bus.rs2_val}, 64'h55);
        check_eq("instret3", bus.instret, 64'd3);

        // Rename under flush is dropped
        rename(5'd8, 4'd4); bus.flush = 1'b1; step(); idle();
        bus.rs1_addr = 5'd8;
        #1;
        check_eq("flush_rn_rdy", {63'd0, bus.rs1_ready}, 64'd1);
        check_eq("flush_rn_val", {32'd0, bus.rs1_val}, 64'd0);

        // Flush restores last committed value of x9
        commit(5'd9, 4'd1, 32'h77); step(); idle();
        rename(5'd9, 4'd5); step(); idle();
        bus.rs2_addr = 5'd9;
        #1;
        check_eq("x9_busy", {32'd0, bus.rs2_val}, 64'd5);
        bus.flush = 1'b1; step(); idle();
        #1;
        check_eq("x9_flush_rdy", {63'd0, bus.rs2_ready}, 64'd1);
        check_eq("x9_flush_val", {32'd0, bus.rs2_val}, 64'h77);

        // Commit during flush still writes and counts
        rename(5'd10, 4'd6); step(); idle();
        bus.flush = 1'b1; commit(5'd10, 4'd6, 32'hAB); step(); idle();
        bus.rs1_addr = 5'd10;
        #1;
        check_eq("flush_cm_val", {32'd0, bus.rs1_val}, 64'hAB);
        check_eq("instret5", bus.instret, 64'd5);

        // Rename and commit same rd same cycle
        rename(5'd11, 4'd1); step(); idle();
        rename(5'd11, 4'd9); commit(5'd11, 4'd1, 32'h11); step(); idle();
        bus.rs1_addr = 5'd11;
        #1;
        check_eq("rn_cm_rdy", {63'd0, bus.rs1_ready}, 64'd0);
        check_eq("rn_cm_tag", {32'd0, bus.rs1_val}, 64'd9);
        bus.flush = 1'b1; step(); idle();
        #1;
        check_eq("rn_cm_reg", {32'd0, bus.rs1_val}, 64'h11);

        // x0 is never renamed or written, but its commit counts
        rename(5'd0, 4'd1); commit(5'd0, 4'd0, 32'hFF);
        bus.rs1_addr = 5'd0;
        step(); idle();
        #1;
        check_eq("x0_rdy", {63'd0, bus.rs1_ready}, 64'd1);
        check_eq("x0_val", {32'd0, bus.rs1_val}, 64'd0);
        check_eq("instret7", bus.instret, 64'd7);

        // rdy=0 holds all state; reads stay live
        bus.rdy = 1'b0;
        commit(5'd12, 4'd0, 32'h123); rename(5'd13, 4'd2);
        bus.rs2_addr = 5'd10;
        #1;
        check_eq("hold_read", {32'd0, bus.rs2_val}, 64'hAB);
        step(); idle();
        bus.rdy = 1'b1;
        bus.rs1_addr = 5'd12; bus.rs2_addr = 5'd13;
        #1;
        check_eq("hold_x12", {32'd0, bus.rs1_val}, 64'd0);
        check_eq("hold_x13", {63'd0, bus.rs2_ready}, 64'd1);
        check_eq("hold_instret", bus.instret, 64'd7);

        // Reset mid-operation discards pending renames and values
        rename(5'd14, 4'd3); step(); idle();
        rst = 1'b1; rename(5'd13, 4'd4); step(); idle();
        rst = 1'b0;
        bus.rs1_addr = 5'd14; bus.rs2_addr = 5'd5;
        #1;
        check_eq("rst2_x14", {63'd0, bus.rs1_ready}, 64'd1);
        check_eq("rst2_x5", {32'd0, bus.rs2_val}, 64'd0);
        check_eq("rst2_instret", bus.instret, 64'd0);
        bus.rs1_addr = 5'd13;
        #1;
        check_eq("rst2_x13", {63'd0, bus.rs1_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
